// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory, fetch buffer and redirect signals of the fetch unit
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [3:0]  function_code;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack,
        output instr_valid,
        input  instr_ready,
        output instr,
        output opcode,
        output function_code,
        output instr_pc,
        input  redirect_valid,
        input  redirect_pc,
        output halted
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  opcode,
        input  function_code,
        input  instr_pc,
        output redirect_valid,
        output redirect_pc,
        input  halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-entry instruction fetch buffer with redirect/flush; IFU_HALT_EN adds HALT stop
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1
`ifdef IFU_HALT_EN
        ,
        ST_HALT = 2'd2
`endif
    } state_t;

    state_t      state_q;
    state_t      state_nxt;
    logic [15:0] pc_q;
    logic [15:0] hold_addr_q;
    logic [15:0] instr_q;
    logic [15:0] instr_pc_q;
    logic        instr_valid_q;
    logic        flush_q;
    logic        in_req;
    logic        load;
    logic        consume;

    assign in_req  = (state_q == ST_REQ);
    // A returning word is only kept when no redirect has touched the request.
    assign load    = in_req && bus.imem_ack && !flush_q && !bus.redirect_valid;
    assign consume = instr_valid_q && bus.instr_ready;

`ifdef IFU_HALT_EN
    logic halted_q;
    logic halt_load;

    assign halt_load = load && (bus.imem_rdata[15:12] == 4'b1111);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!instr_valid_q || bus.instr_ready) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    state_nxt = ST_IDLE;
`ifdef IFU_HALT_EN
                    if (halt_load) begin
                        state_nxt = ST_HALT;
                    end
`endif
                end
            end
`ifdef IFU_HALT_EN
            ST_HALT: begin
                if (bus.redirect_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // While flushing, pc already holds the redirect target, so the bus keeps the old address.
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.imem_addr = pc_q;
        if (in_req) begin
            bus.imem_req = 1'b1;
            if (flush_q) begin
                bus.imem_addr = hold_addr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0000;
            instr_pc_q    <= 16'h0000;
            instr_valid_q <= 1'b0;
        end else begin
            if (bus.redirect_valid) begin
                pc_q          <= bus.redirect_pc;
                instr_valid_q <= 1'b0;
            end else if (load) begin
                instr_q       <= bus.imem_rdata;
                instr_pc_q    <= pc_q;
                instr_valid_q <= 1'b1;
                pc_q          <= pc_q + 16'd1;
            end else if (consume) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_q     <= 1'b0;
            hold_addr_q <= 16'h0000;
        end else if (in_req) begin
            if (bus.imem_ack) begin
                flush_q <= 1'b0;
            end else if (bus.redirect_valid) begin
                flush_q <= 1'b1;
                if (!flush_q) begin
                    hold_addr_q <= pc_q;
                end
            end
        end
    end

`ifdef IFU_HALT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            halted_q <= 1'b0;
        end else if (halt_load) begin
            halted_q <= 1'b1;
        end
    end

    assign bus.halted = halted_q;
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.instr_valid   = instr_valid_q;
    assign bus.instr         = instr_q;
    assign bus.instr_pc      = instr_pc_q;
    assign bus.opcode        = instr_q[15:12];
    assign bus.function_code = instr_q[3:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus_w ();

    instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFF)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w.master)
    );

    logic        auto_ack;
    logic        manual_ack;
    logic        use_manual;
    logic [15:0] manual_rdata;

    assign bus.imem_ack   = auto_ack ? bus.imem_req : manual_ack;
    assign bus.imem_rdata = use_manual ? manual_rdata : (bus.imem_addr ^ 16'h5A00);

    // The wrap instance always sees a zero-wait memory and a ready consumer.
    assign bus_w.imem_ack       = bus_w.imem_req;
    assign bus_w.imem_rdata     = bus_w.imem_addr ^ 16'h5A00;
    assign bus_w.instr_ready    = 1'b1;
    assign bus_w.redirect_valid = 1'b0;
    assign bus_w.redirect_pc    = 16'h0000;

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n              = 1'b0;
        auto_ack           = 1'b1;
        manual_ack         = 1'b0;
        use_manual         = 1'b0;
        manual_rdata       = 16'h0000;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;

        tick(); tick(); tick();
        check("rst_req",    {15'd0, bus.imem_req},    16'h0000);
        check("rst_valid",  {15'd0, bus.instr_valid}, 16'h0000);
        check("rst_instr",  bus.instr,                16'h0000);
        check("rst_ipc",    bus.instr_pc,             16'h0000);
        check("rst_halted", {15'd0, bus.halted},      16'h0000);

        // sequential fetch, zero-wait memory
        rst_n = 1'b1;
        check("first_cycle_noreq", {15'd0, bus.imem_req}, 16'h0000);
        tick();
        check("seq0_req",   {15'd0, bus.imem_req}, 16'h0001);
        check("seq0_addr",  bus.imem_addr,         16'h0000);
        check("wrap0_addr", bus_w.imem_addr,       16'hFFFF);
        tick();
        check("seq0_noreq", {15'd0, bus.imem_req},    16'h0000);
        check("seq0_valid", {15'd0, bus.instr_valid}, 16'h0001);
        check("seq0_instr", bus.instr,                16'h5A00);
        check("seq0_ipc",   bus.instr_pc,             16'h0000);
        check("wrap0_ipc",  bus_w.instr_pc,           16'hFFFF);
        check("wrap0_ins",  bus_w.instr,              16'hA5FF);
        tick();
        check("seq1_addr",  bus.imem_addr,            16'h0001);
        check("seq1_req",   {15'd0, bus.imem_req},    16'h0001);
        check("wrap1_addr", bus_w.imem_addr,          16'h0000);
        tick();
        check("seq1_ipc",   bus.instr_pc,             16'h0001);
        check("seq1_instr", bus.instr,                16'h5A01);
        check("wrap1_ipc",  bus_w.instr_pc,           16'h0000);
        tick();
        check("seq2_addr",  bus.imem_addr,            16'h0002);
        tick();
        check("seq2_ipc",   bus.instr_pc,             16'h0002);

        // backpressure with 0123 buffered
        use_manual   = 1'b1;
        manual_rdata = 16'h0123;
        tick();
        check("bp_addr", bus.imem_addr, 16'h0003);
        bus.instr_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",  {15'd0, bus.instr_valid}, 16'h0001);
            check("bp_instr",  bus.instr,                16'h0123);
            check("bp_opcode", {12'd0, bus.opcode},      16'h0000);
            check("bp_fcode",  {12'd0, bus.function_code}, 16'h0003);
            check("bp_noreq",  {15'd0, bus.imem_req},    16'h0000);
            tick();
        end
        check("bp_ipc", bus.instr_pc, 16'h0003);
        bus.instr_ready = 1'b1;
        auto_ack        = 1'b0;
        tick();
        check("bp_resume_req",  {15'd0, bus.imem_req}, 16'h0001);
        check("bp_resume_addr", bus.imem_addr,         16'h0004);

        // redirect while the request to 0004 is outstanding
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0040;
        manual_rdata       = 16'h1111;
        tick();
        bus.redirect_valid = 1'b0;
        check("fl_hold1", bus.imem_addr,         16'h0004);
        check("fl_req1",  {15'd0, bus.imem_req}, 16'h0001);
        tick();
        check("fl_hold2", bus.imem_addr, 16'h0004);
        tick();
        check("fl_hold3", bus.imem_addr, 16'h0004);
        manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        check("fl_drop_valid", {15'd0, bus.instr_valid}, 16'h0000);
        check("fl_drop_instr", bus.instr,                16'h0123);
        check("fl_noreq",      {15'd0, bus.imem_req},    16'h0000);
        tick();
        check("fl_new_req",  {15'd0, bus.imem_req}, 16'h0001);
        check("fl_new_addr", bus.imem_addr,         16'h0040);

        // complete 0040, then redirect to 0007 while buffer is consumed
        manual_rdata = 16'h2222;
        manual_ack   = 1'b1;
        tick();
        manual_ack = 1'b0;
        check("r40_instr", bus.instr,    16'h2222);
        check("r40_ipc",   bus.instr_pc, 16'h0040);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0007;
        tick();
        bus.redirect_valid = 1'b0;
        check("r7_valid", {15'd0, bus.instr_valid}, 16'h0000);
        check("r7_addr",  bus.imem_addr,            16'h0007);

        // redirect and ack in the same cycle
        manual_rdata       = 16'h3333;
        manual_ack         = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0100;
        tick();
        manual_ack         = 1'b0;
        bus.redirect_valid = 1'b0;
        check("sim_valid", {15'd0, bus.instr_valid}, 16'h0000);
        check("sim_instr", bus.instr,                16'h2222);
        check("sim_noreq", {15'd0, bus.imem_req},    16'h0000);
        tick();
        check("sim_addr", bus.imem_addr, 16'h0100);

        // redirect clears a held buffer even without ready
        auto_ack        = 1'b1;
        use_manual      = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        check("rh_instr", bus.instr,    16'h5B00);
        check("rh_ipc",   bus.instr_pc, 16'h0100);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0020;
        tick();
        bus.redirect_valid = 1'b0;
        check("rh_valid", {15'd0, bus.instr_valid}, 16'h0000);
        tick();
        check("rh_addr", bus.imem_addr, 16'h0020);
        tick();
        check("rh_ipc2", bus.instr_pc, 16'h0020);

        // ack in IDLE is ignored
        auto_ack     = 1'b0;
        use_manual   = 1'b1;
        manual_rdata = 16'h4444;
        manual_ack   = 1'b1;
        tick();
        manual_ack = 1'b0;
        check("idle_ack_instr", bus.instr,             16'h5A20);
        check("idle_ack_req",   {15'd0, bus.imem_req}, 16'h0000);

        // reset in the middle of a request, late ack ignored
        bus.instr_ready = 1'b1;
        tick();
        check("mr_addr", bus.imem_addr, 16'h0021);
        rst_n = 1'b0;
        tick();
        check("mr_noreq", {15'd0, bus.imem_req}, 16'h0000);
        manual_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        manual_ack = 1'b0;
        check("mr_valid", {15'd0, bus.instr_valid}, 16'h0000);
        check("mr_addr0", bus.imem_addr,            16'h0000);
        check("mr_req",   {15'd0, bus.imem_req},    16'h0001);
        tick();
        check("mr_hold", bus.imem_addr,         16'h0000);
        check("mr_hreq", {15'd0, bus.imem_req}, 16'h0001);
        auto_ack   = 1'b1;
        use_manual = 1'b0;
        tick();
        check("mr_ipc", bus.instr_pc, 16'h0000);
        tick();
        tick();
        check("mr_ipc1", bus.instr_pc, 16'h0001);

        // opcode 1111 word at 0002
        use_manual   = 1'b1;
        manual_rdata = 16'hF000;
        tick();
        check("h_addr", bus.imem_addr, 16'h0002);
        tick();
        use_manual = 1'b0;
        check("h_instr",  bus.instr,             16'hF000);
        check("h_opcode", {12'd0, bus.opcode},   16'h000F);
        check("h_ipc",    bus.instr_pc,          16'h0002);
`ifdef IFU_HALT_EN
        check("h_halted", {15'd0, bus.halted},   16'h0001);
        tick();
        check("h_req0",    {15'd0, bus.imem_req},    16'h0000);
        check("h_valid0",  {15'd0, bus.instr_valid}, 16'h0000);
        check("h_halted1", {15'd0, bus.halted},      16'h0001);
        tick();
        check("h_req1", {15'd0, bus.imem_req}, 16'h0000);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0010;
        tick();
        bus.redirect_valid = 1'b0;
        check("h_clear", {15'd0, bus.halted}, 16'h0000);
        tick();
        check("h_resume_req",  {15'd0, bus.imem_req}, 16'h0001);
        check("h_resume_addr", bus.imem_addr,         16'h0010);
`else
        check("h_nohalt", {15'd0, bus.halted}, 16'h0000);
        tick();
        check("h_next_req",  {15'd0, bus.imem_req}, 16'h0001);
        check("h_next_addr", bus.imem_addr,         16'h0003);
        check("h_nohalt2",   {15'd0, bus.halted},   16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: word address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  16  word address of the request.
REQ-006 imem_rdata  input  16  read data, valid in the cycle imem_ack=1.
REQ-007 imem_ack  input  1  request complete, one-cycle pulse.
REQ-008 instr_valid  output  1  output buffer holds an instruction.
REQ-009 instr_ready  input  1  downstream consumes the buffer this cycle when instr_valid=1.
REQ-010 instr  output  16  buffered instruction word.
REQ-011 opcode  output  4  instr[15:12], feeds control decode.
REQ-012 function_code  output  4  instr[3:0], feeds control decode.
REQ-013 instr_pc  output  16  address the buffered instruction was fetched from.
REQ-014 redirect_valid  input  1  taken branch or jump, one-cycle pulse.
REQ-015 redirect_pc  input  16  new fetch address, sampled when redirect_valid=1.
REQ-016 halted  output  1  fetch stopped on HALT; tied 0 when the halt feature is compiled out.

Function
REQ-017 Addressing SHALL be word-based: the next PC is pc+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-018 The FSM SHALL have states IDLE, REQ and, when the halt feature is compiled in, HALT.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; both SHALL hold stable until imem_ack.
REQ-020 In IDLE and HALT, imem_req SHALL be 0.
REQ-021 On imem_ack in REQ with no flush pending, the block SHALL load instr<=imem_rdata, instr_pc<=pc, instr_valid<=1 and pc<=pc+1, then go to IDLE.
REQ-022 In IDLE, the FSM SHALL go to REQ in the cycle after the buffer is empty or instr_valid&instr_ready=1; otherwise it SHALL stay in IDLE.
REQ-023 instr_valid SHALL clear on instr_valid&instr_ready unless a new load occurs in the same cycle; minimum throughput SHALL be one instruction per 2 cycles with zero-wait memory.
REQ-024 On redirect_valid, the block SHALL set pc<=redirect_pc and instr_valid<=0 in the same edge, regardless of instr_ready.
REQ-025 On redirect_valid in REQ without imem_ack, a flush flag SHALL be set, the outstanding request SHALL complete at the old address, its data SHALL be discarded, and the next request SHALL use redirect_pc.
REQ-026 On redirect_valid with imem_ack in the same cycle, the returned data SHALL be discarded and pc SHALL take redirect_pc, not pc+1.
REQ-027 imem_ack outside REQ SHALL be ignored.
REQ-028 opcode and function_code SHALL be combinational slices of the instr register.

Reset
REQ-029 With rst_n=0 at a rising edge: pc<=RESET_PC, state<=IDLE, instr<=16'h0000, instr_pc<=16'h0000, instr_valid<=0, flush<=0, halted<=0.
REQ-030 During reset imem_req SHALL be 0; the first imem_req SHALL assert in the second cycle after rst_n rises.
REQ-031 Reset asserted mid-request SHALL abandon the request; a later imem_ack SHALL be ignored.

Configuration
REQ-032 Macro IFU_HALT_EN: when defined, loading a word with opcode 4'b1111 SHALL deliver it to the buffer normally, then set halted=1 and enter HALT with no further requests until reset or redirect_valid, which clears halted and resumes at redirect_pc.
REQ-033 When IFU_HALT_EN is undefined, opcode 4'b1111 SHALL be fetched as an ordinary instruction, and halted SHALL be constant 0.

Verification
REQ-034 Sequential fetch: reset, memory with ack in the same cycle, instr_ready=1 -> addresses 0000, 0001, 0002 issued on every second cycle; instr_pc matches each address.
REQ-035 Backpressure: instr_ready=0 for 5 cycles with word 16'h0123 buffered -> instr held, opcode=0, function_code=3, no imem_req; resumes one cycle after ready.
REQ-036 Redirect in flight: request to 0004 with ack delayed 3 cycles, redirect_pc=0040 in cycle 1 -> addr 0004 held until ack, data dropped, next request at 0040.
REQ-037 Simultaneous redirect and ack: redirect_pc=0100 with ack at 0007 -> instr_valid=0, next request at 0100.
REQ-038 Wrap: RESET_PC=16'hFFFF -> fetches FFFF then 0000.
REQ-039 With IFU_HALT_EN, word F000 at 0002 -> F000 delivered, halted=1, no requests; redirect to 0010 -> halted=0, fetch at 0010.
